multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
Parametrised multicycle control unit for the CPU datapath. It decodes the instruction-register opcode and sequences fetch, decode, execute, memory and write-back states. It drives every datapath mux and write-enable. Unlike the fixed 4-bit controller, it has configurable opcode and ALU-control widths, variable-latency memory via a ready handshake, a HALT state, and an illegal-opcode trap.

Parameters:
OP_W, 4, opcode width (min 4; opcodes decoded below are zero-extended constants)
ALUCTL_W, 3, width of ALUControl and funct
ALU_ADD, 0, ALUControl code for add
ALU_SUB, 1, ALUControl code for subtract
TRAP_EN, 1, 1 = illegal opcode traps; 0 = illegal opcode is treated as NOP (returns to FETCH)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
op  in  OP_W  opcode from instruction register
funct  in  ALUCTL_W  function field for R-type instructions
mem_ready  in  1  memory completes the current access this cycle
ReadAddr  out  1  register-file read-address select (0=rs/rt, 1=rd/rt for SW)
IRWrite  out  1  load instruction register
ALUA  out  1  ALU A select (0=PC, 1=regA)
ALUB  out  2  ALU B select (0=regB, 1=const 1, 2=sign-ext imm, 3=jump offset)
ALUControl  out  ALUCTL_W  ALU operation
MemAddr  out  1  memory address select (0=PC, 1=ALUOut)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
PCSource  out  2  next-PC select (0=ALU, 1=ALUOut, 2=jump target, 3=trap vector)
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
RegWrite  out  1  register-file write
MemToReg  out  1  write-back data select (0=ALUOut, 1=MDR)
state  out  4  current state code, for debug
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on trap

Behaviour:
- Opcodes: 0=RTYPE, 1=ADDI, 2=LW, 3=SW, 4=BEQ, 5=JUMP, all-ones=HALT. Every other value is illegal.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEMRD=5, MEMWR=6, WB_R=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11, TRAP=12.
- The state register is updated on posedge CLK. When Reset=0, state becomes FETCH asynchronously.
- All outputs are combinational from state (and mem_ready where noted). With Reset=0, every output is 0, state=0 and ALUControl=ALU_ADD.
- FETCH:
  - MemRead=1, MemAddr=0, ALUA=0, ALUB=1, ALUControl=ALU_ADD, PCSource=0.
  - IRWrite and PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - ALUA=0, ALUB=3, ALUControl=ALU_ADD (precomputes the branch target).
  - Next state by opcode: RTYPE->EXEC_R; ADDI->EXEC_I; LW/SW->ADDR; BEQ->BRANCH; JUMP->JUMP; HALT->HALT.
  - Illegal opcode -> TRAP if TRAP_EN=1, else FETCH.
- EXEC_R: ALUA=1, ALUB=0, ALUControl=funct. Go to WB_R.
- EXEC_I: ALUA=1, ALUB=2, ALUControl=ALU_ADD. Go to WB_R.
- WB_R: RegWrite=1, MemToReg=0. Go to FETCH.
- ADDR:
  - ALUA=1, ALUB=2, ALUControl=ALU_ADD.
  - Next state: LW->MEMRD; SW->MEMWR. ReadAddr=1 for SW.
- MEMRD: MemRead=1, MemAddr=1. Wait here while mem_ready=0; go to WB_MEM when mem_ready=1.
- MEMWR:
  - MemAddr=1, ReadAddr=1.
  - MemWrite=1 is held every cycle until mem_ready=1, then go to FETCH.
- WB_MEM: RegWrite=1, MemToReg=1. Go to FETCH.
- BRANCH: ALUA=1, ALUB=0, ALUControl=ALU_SUB, PCWriteCond=1, PCSource=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=2. Go to FETCH.
- HALT: halted=1, all write enables 0. Remain in HALT until Reset.
- TRAP: PCWrite=1, PCSource=3, illegal=1. Go to FETCH.
- Latencies with mem_ready tied to 1:
  - R/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, JUMP, TRAP: 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Write-enable invariants:
  - At most one of RegWrite, MemWrite, PCWrite/PCWriteCond, IRWrite is high in any state, except FETCH, where IRWrite and PCWrite are both high.
  - No write enable is high in DECODE.
- Reset asserted mid-instruction aborts it immediately. No write enable may glitch high during reset.
- Unused state codes 13-15 go to FETCH on the next edge, with all outputs 0.

Test Plan:
- Reset low 3 cycles, then release with op=0, funct=5, mem_ready=1 -> state sequence 0,1,2,7,0. ALUControl=5 in EXEC_R. RegWrite=1 only in WB_R.
- op=2 (LW), mem_ready low for 2 cycles in MEMRD -> states 0,1,4,5,5,5,8,0. MemRead held high in MEMRD. RegWrite=1 with MemToReg=1 in WB_MEM.
- op=3 (SW), mem_ready low in FETCH for 1 cycle -> IRWrite=0 on the first FETCH cycle and 1 on the second. MemWrite held high in MEMWR until ready. No RegWrite pulse.
- op=4 then op=5 -> BRANCH asserts PCWriteCond=1, PCSource=1, ALUControl=ALU_SUB. JUMP asserts PCWrite=1, PCSource=2. Each instruction takes 3 cycles.
- op=7 with TRAP_EN=1 -> TRAP state (12). illegal pulses for exactly 1 cycle with PCSource=3. With TRAP_EN=0, DECODE goes straight to FETCH and illegal stays 0.
- op=4'hF -> HALT entered, halted=1 stays for 20 cycles, no write enables. Reset pulsed low mid-state -> state 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle controller and the CPU datapath.
// The controller is the master, and the datapath side is the slave.
interface multicycle_ctrl_fsm_if #(
  parameter int OP_W     = 4,
  parameter int ALUCTL_W = 3
);
  logic [OP_W-1:0]     op;
  logic [ALUCTL_W-1:0] funct;
  logic                mem_ready;
  logic                ReadAddr;
  logic                IRWrite;
  logic                ALUA;
  logic [1:0]          ALUB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                MemAddr;
  logic                MemRead;
  logic                MemWrite;
  logic [1:0]          PCSource;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                RegWrite;
  logic                MemToReg;
  logic [3:0]          state;
  logic                halted;
  logic                illegal;

  modport master (
    input  op, funct, mem_ready,
    output ReadAddr, IRWrite, ALUA, ALUB, ALUControl, MemAddr, MemRead, MemWrite,
           PCSource, PCWrite, PCWriteCond, RegWrite, MemToReg, state, halted, illegal
  );

  modport slave (
    output op, funct, mem_ready,
    input  ReadAddr, IRWrite, ALUA, ALUB, ALUControl, MemAddr, MemRead, MemWrite,
           PCSource, PCWrite, PCWriteCond, RegWrite, MemToReg, state, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM. Instructions take 3-5 cycles, and each cycle of mem_ready low adds one cycle.
// Outputs decode from the state register, and they are forced to zero while Reset is low.
module multicycle_ctrl_fsm #(
  parameter int OP_W     = 4,
  parameter int ALUCTL_W = 3,
  parameter int ALU_ADD  = 0,
  parameter int ALU_SUB  = 1,
  parameter bit TRAP_EN  = 1'b1
) (
  input logic CLK,
  input logic Reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEMRD  = 4'd5,  S_MEMWR  = 4'd6,  S_WB_R   = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_HALT   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_HALT  = '1;

  localparam logic [ALUCTL_W-1:0] CTL_ADD = ALUCTL_W'(ALU_ADD);
  localparam logic [ALUCTL_W-1:0] CTL_SUB = ALUCTL_W'(ALU_SUB);

  state_t st;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:  if (bus.mem_ready) st <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_RTYPE:       st <= S_EXEC_R;
            OP_ADDI:        st <= S_EXEC_I;
            OP_LW, OP_SW:   st <= S_ADDR;
            OP_BEQ:         st <= S_BRANCH;
            OP_JUMP:        st <= S_JUMP;
            OP_HALT:        st <= S_HALT;
            default:        st <= TRAP_EN ? S_TRAP : S_FETCH;
          endcase
        end
        S_EXEC_R: st <= S_WB_R;
        S_EXEC_I: st <= S_WB_R;
        S_ADDR:   st <= (bus.op == OP_SW) ? S_MEMWR : ((bus.op == OP_LW) ? S_MEMRD : S_FETCH);
        S_MEMRD:  if (bus.mem_ready) st <= S_WB_MEM;
        S_MEMWR:  if (bus.mem_ready) st <= S_FETCH;
        S_HALT:   st <= S_HALT;
        default:  st <= S_FETCH;
      endcase
    end
  end

  logic                read_addr, ir_write, alu_a, mem_addr, mem_read, mem_write;
  logic                pc_write, pc_write_cond, reg_write, mem_to_reg, halt_flag, trap_pulse;
  logic [1:0]          alu_b, pc_source;
  logic [ALUCTL_W-1:0] alu_ctl;

  // Gating on Reset keeps every write enable low for the whole reset, not just after the next edge.
  always_comb begin
    read_addr = 1'b0; ir_write = 1'b0; alu_a = 1'b0; alu_b = 2'd0; alu_ctl = CTL_ADD;
    mem_addr = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pc_source = 2'd0; pc_write = 1'b0;
    pc_write_cond = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0; halt_flag = 1'b0; trap_pulse = 1'b0;
    if (Reset) begin
      case (st)
        S_FETCH: begin
          mem_read = 1'b1; alu_b = 2'd1;
          ir_write = bus.mem_ready; pc_write = bus.mem_ready;
        end
        S_DECODE: alu_b = 2'd3;
        S_EXEC_R: begin alu_a = 1'b1; alu_ctl = bus.funct; end
        S_EXEC_I: begin alu_a = 1'b1; alu_b = 2'd2; end
        S_ADDR: begin
          alu_a = 1'b1; alu_b = 2'd2;
          read_addr = (bus.op == OP_SW);
        end
        S_MEMRD:  begin mem_read = 1'b1; mem_addr = 1'b1; end
        S_MEMWR:  begin mem_write = 1'b1; mem_addr = 1'b1; read_addr = 1'b1; end
        S_WB_R:   reg_write = 1'b1;
        S_WB_MEM: begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        S_BRANCH: begin alu_a = 1'b1; alu_ctl = CTL_SUB; pc_write_cond = 1'b1; pc_source = 2'd1; end
        S_JUMP:   begin pc_write = 1'b1; pc_source = 2'd2; end
        S_HALT:   halt_flag = 1'b1;
        S_TRAP:   begin pc_write = 1'b1; pc_source = 2'd3; trap_pulse = 1'b1; end
        default:  alu_ctl = '0;
      endcase
    end
  end

  assign bus.ReadAddr    = read_addr;
  assign bus.IRWrite     = ir_write;
  assign bus.ALUA        = alu_a;
  assign bus.ALUB        = alu_b;
  assign bus.ALUControl  = alu_ctl;
  assign bus.MemAddr     = mem_addr;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.PCSource    = pc_source;
  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.RegWrite    = reg_write;
  assign bus.MemToReg    = mem_to_reg;
  assign bus.state       = st;
  assign bus.halted      = halt_flag;
  assign bus.illegal     = trap_pulse;

endmodule
